// File: rtl/bar_fifo.sv
// bar_fifo: first-word-fall-through FIFO between the bar.out producer and the bar.in consumer.
// Flags derive from the registered count only; storage itself carries no reset.
module bar_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             full_s;
  logic             empty_s;
  logic             push_s;
  logic             pop_s;

  // Handshake flags and head-of-queue view, all from registered state (plus rst gating in_ready)
  always_comb begin
    full_s    = (count_r == CW'(DEPTH));
    empty_s   = (count_r == {CW{1'b0}});
    in_ready  = !full_s && !rst;
    out_valid = !empty_s;
    push_s    = in_valid && in_ready;
    pop_s     = out_valid && out_ready;
    out_data  = mem_r[rd_ptr_r];
    count     = count_r;
  end

  // Pointer and occupancy registers; pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Payload storage, written only on a push edge
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= in_data;
    end
  end

endmodule

// File: doc/bar_fifo.md
BAR_FIFO -- requirements
Module: bar_fifo

Interface
REQ-001 Parameter WIDTH, default 32, payload width in bits; matches the 32-bit data field of the bar interface.
REQ-002 Parameter DEPTH, default 4, number of storage entries; a power of two, >= 2.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_data  input  WIDTH  upstream payload; bar.out-side producer drives it.
REQ-006 in_valid  input  1  upstream payload valid.
REQ-007 in_ready  output  1  FIFO can accept a word this cycle.
REQ-008 out_data  output  WIDTH  head-of-queue payload toward the bar.in-side consumer.
REQ-009 out_valid  output  1  out_data holds a valid word.
REQ-010 out_ready  input  1  downstream accepts the head word this cycle.
REQ-011 count  output  $clog2(DEPTH)+1  current number of stored words, 0..DEPTH.

Function
REQ-012 Push: occurs on a rising edge where in_valid && in_ready; in_data is written at the write pointer and the write pointer advances by 1.
REQ-013 Pop: occurs on a rising edge where out_valid && out_ready; the read pointer advances by 1.
REQ-014 Pointers are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0 with no gap or stall.
REQ-015 count update per edge: push only, +1; pop only, -1; both or neither, unchanged.
REQ-016 in_ready is 1 exactly when count < DEPTH and rst is low, and is combinational from registered state only (no path from out_ready).
REQ-017 out_valid is 1 exactly when count > 0, with no combinational path from in_valid.
REQ-018 out_data always shows the entry at the read pointer, so data is first-word-fall-through once registered.
REQ-019 Latency: a word pushed into an empty FIFO at edge N appears on out_data/out_valid after edge N; there is no same-cycle bypass.
REQ-020 Full (count == DEPTH): in_ready = 0; in_valid is ignored even when a pop occurs in the same cycle; the upstream stage retries next cycle.
REQ-021 Empty (count == 0): out_valid = 0; out_ready is ignored; out_data is don't-care.
REQ-022 Simultaneous push and pop with 0 < count < DEPTH: both pointers advance and count holds.
REQ-023 While out_valid && !out_ready, out_data and out_valid remain stable until the pop.
REQ-024 Ordering is strict FIFO: no word is lost, duplicated or reordered.
REQ-025 in_data is sampled only on a push edge; its value in other cycles has no effect.

Reset
REQ-026 Asserting rst clears, immediately and independently of clk: the read pointer, the write pointer and count (all to 0), which forces out_valid = 0 and in_ready = 0.
REQ-027 Storage entries are not reset; out_data is don't-care until the first push.
REQ-028 Reset mid-operation discards all stored words; no pop or push completes on the edge coincident with rst.
REQ-029 On the first rising edge after rst deasserts, in_ready = 1 and count = 0.

Verification
REQ-030 Reset then idle -> out_valid = 0, in_ready = 1, count = 0 for 10 cycles.
REQ-031 Push 0xA5A5_0001, out_ready = 0 -> after the next edge: out_valid = 1, out_data = 0xA5A5_0001, count = 1; data stays stable for 5 held cycles.
REQ-032 Push 0x1..0x4 with out_ready = 0 (DEPTH = 4) -> count = 4, in_ready = 0; 0x5 is offered with in_valid high and is not accepted.
REQ-033 Then drain with out_ready = 1 -> 0x1, 0x2, 0x3, 0x4 appear on consecutive cycles, then out_valid = 0 and count = 0.
REQ-034 Continuous in_valid = out_ready = 1 over 20 words 0x10..0x23 -> in-order output, count settles at 1, pointers wrap at least 4 times, and no bubbles appear after the first word.
REQ-035 Fill 3 words, then assert rst asynchronously mid-cycle -> out_valid and in_ready drop before the next edge, count = 0, and no stale word reappears after release.
